// File: rtl/code_fetch_unit_pkg.sv
// Shared definitions for the code fetch unit: fetch FSM states, next-PC
// select codes and the instruction substituted for out-of-range fetches.
package code_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_LOADED  = 2'd2,
    ST_RUNNING = 2'd3
  } fetch_state_e;

  localparam logic [1:0] PC_SEL_PLUS_1 = 2'd0;
  localparam logic [1:0] PC_SEL_JT     = 2'd1;
  localparam logic [1:0] PC_SEL_JF     = 2'd2;
  localparam logic [1:0] PC_SEL_IMM    = 2'd3;

  // "return 0" style word: makes the program reject when fetched out of range
  localparam logic [63:0] RET_REJECT_INSTR = 64'h0000_0006_0000_0000;

endpackage

// File: rtl/code_fetch_unit_code_mem.sv
// code_mem: simple dual-port code RAM, one write port and one synchronous
// read port with one cycle of latency. The read register holds its value
// when no read is requested.
module code_mem
  import code_fetch_unit_pkg::*;
#(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int INSTR_WIDTH     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [CODE_ADDR_WIDTH-1:0] waddr,
  input  logic [INSTR_WIDTH-1:0]     wdata,
  input  logic                       re,
  input  logic [CODE_ADDR_WIDTH-1:0] raddr,
  output logic [INSTR_WIDTH-1:0]     rdata
);

  logic [INSTR_WIDTH-1:0] mem_q [0:(2**CODE_ADDR_WIDTH)-1];
  logic [INSTR_WIDTH-1:0] rdata_d;
  logic [INSTR_WIDTH-1:0] rdata_q;

  // Storage array write port (no reset on RAM contents)
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Next read data: new word on a read request, otherwise hold
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/code_fetch_unit.sv
// code_fetch_unit: owns the program counter and the code memory. Programs
// arrive over an AXI-Stream style port; execution runs from start until the
// controller signals acc/rej. Optional feature macro FETCH_OOB_CHECK_EN:
// fetches at PC >= prog_len return RET_REJECT_INSTR and set sticky oob_err.
module code_fetch_unit
  import code_fetch_unit_pkg::*;
#(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int INSTR_WIDTH     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INSTR_WIDTH-1:0]     code_tdata,
  input  logic                       code_tvalid,
  input  logic                       code_tlast,
  output logic                       code_tready,
  input  logic                       start,
  input  logic                       inst_rd_en,
  input  logic                       PC_en,
  input  logic [1:0]                 PC_sel,
  input  logic [7:0]                 jt,
  input  logic [7:0]                 jf,
  input  logic [31:0]                imm,
  input  logic [CODE_ADDR_WIDTH-1:0] jmp_correction,
  input  logic                       acc,
  input  logic                       rej,
  output logic [INSTR_WIDTH-1:0]     instr_out,
  output logic                       instr_vld,
  output logic                       running,
  output logic [CODE_ADDR_WIDTH:0]   prog_len,
  output logic                       load_ovf,
  output logic                       oob_err
);

  localparam logic [CODE_ADDR_WIDTH-1:0] ADDR_MAX = {CODE_ADDR_WIDTH{1'b1}};
  localparam logic [CODE_ADDR_WIDTH-1:0] ADDR_ONE = {{(CODE_ADDR_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_e                 state_d, state_q;
  logic [CODE_ADDR_WIDTH-1:0]   pc_d, pc_q, pc_next_s;
  logic [CODE_ADDR_WIDTH-1:0]   wr_ptr_d, wr_ptr_q, wr_addr_s;
  logic [CODE_ADDR_WIDTH:0]     prog_len_d, prog_len_q;
  logic                         load_ovf_d, load_ovf_q;
  logic                         oob_err_d, oob_err_q;
  logic                         instr_vld_d, instr_vld_q;
  logic                         rej_sel_d, rej_sel_q;
  logic                         beat_s, last_s, ovf_s, fetch_s, oob_s, mem_re_s;
  logic [INSTR_WIDTH-1:0]       mem_rdata_s;
  logic                         imm_unused_s;

  assign code_tready  = (state_q != ST_RUNNING);
  assign beat_s       = code_tvalid & code_tready;
  // a beat in EMPTY/LOADED is the first beat of a new program
  assign wr_addr_s    = (state_q == ST_LOADING) ? wr_ptr_q : {CODE_ADDR_WIDTH{1'b0}};
  assign ovf_s        = (wr_addr_s == ADDR_MAX) & ~code_tlast;
  assign last_s       = code_tlast | (wr_addr_s == ADDR_MAX);
  // completion takes priority over any fetch in the same cycle
  assign fetch_s      = (state_q == ST_RUNNING) & inst_rd_en & ~(acc | rej);
  assign mem_re_s     = fetch_s & ~oob_s;
  assign imm_unused_s = ^imm[31:CODE_ADDR_WIDTH];

`ifdef FETCH_OOB_CHECK_EN
  assign oob_s = ({1'b0, pc_q} >= prog_len_q);
`else
  assign oob_s = 1'b0;
`endif

  // Next-PC arithmetic from the pre-update PC, modulo the address space
  always_comb begin
    pc_next_s = pc_q + ADDR_ONE;
    case (PC_sel)
      PC_SEL_PLUS_1: pc_next_s = pc_q + ADDR_ONE;
      PC_SEL_JT:     pc_next_s = pc_q - jmp_correction + CODE_ADDR_WIDTH'(jt) + ADDR_ONE;
      PC_SEL_JF:     pc_next_s = pc_q - jmp_correction + CODE_ADDR_WIDTH'(jf) + ADDR_ONE;
      PC_SEL_IMM:    pc_next_s = pc_q - jmp_correction + CODE_ADDR_WIDTH'(imm) + ADDR_ONE;
      default:       pc_next_s = pc_q + ADDR_ONE;
    endcase
  end

  // Fetch FSM: load sequencing, start/done, PC update and fetch bookkeeping
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wr_ptr_d    = wr_ptr_q;
    prog_len_d  = prog_len_q;
    load_ovf_d  = load_ovf_q;
    oob_err_d   = oob_err_q;
    instr_vld_d = 1'b0;
    rej_sel_d   = rej_sel_q;
    case (state_q)
      ST_EMPTY, ST_LOADING, ST_LOADED: begin
        if (beat_s) begin
          load_ovf_d = ovf_s;
          if (last_s) begin
            state_d    = ST_LOADED;
            prog_len_d = {1'b0, wr_addr_s} + {{CODE_ADDR_WIDTH{1'b0}}, 1'b1};
            wr_ptr_d   = {CODE_ADDR_WIDTH{1'b0}};
          end else begin
            state_d  = ST_LOADING;
            wr_ptr_d = wr_addr_s + ADDR_ONE;
          end
        end else if (start && (state_q == ST_LOADED)) begin
          state_d   = ST_RUNNING;
          pc_d      = {CODE_ADDR_WIDTH{1'b0}};
          oob_err_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUNNING: begin
        if (acc || rej) begin
          state_d = ST_LOADED;
          pc_d    = {CODE_ADDR_WIDTH{1'b0}};
        end else begin
          if (fetch_s) begin
            instr_vld_d = 1'b1;
            rej_sel_d   = oob_s;
            oob_err_d   = oob_err_q | oob_s;
          end else begin
            rej_sel_d = rej_sel_q;
          end
          if (PC_en) begin
            pc_d = pc_next_s;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      pc_q        <= '0;
      wr_ptr_q    <= '0;
      prog_len_q  <= '0;
      load_ovf_q  <= 1'b0;
      oob_err_q   <= 1'b0;
      instr_vld_q <= 1'b0;
      rej_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wr_ptr_q    <= wr_ptr_d;
      prog_len_q  <= prog_len_d;
      load_ovf_q  <= load_ovf_d;
      oob_err_q   <= oob_err_d;
      instr_vld_q <= instr_vld_d;
      rej_sel_q   <= rej_sel_d;
    end
  end

  code_mem #(
    .CODE_ADDR_WIDTH (CODE_ADDR_WIDTH),
    .INSTR_WIDTH     (INSTR_WIDTH)
  ) u_code_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (beat_s),
    .waddr (wr_addr_s),
    .wdata (code_tdata),
    .re    (mem_re_s),
    .raddr (pc_q),
    .rdata (mem_rdata_s)
  );

  assign instr_out = rej_sel_q ? INSTR_WIDTH'(RET_REJECT_INSTR) : mem_rdata_s;
  assign instr_vld = instr_vld_q;
  assign running   = (state_q == ST_RUNNING);
  assign prog_len  = prog_len_q;
  assign load_ovf  = load_ovf_q;
  assign oob_err   = oob_err_q;

endmodule

// File: tb/tb_code_fetch_unit.sv
// Scoreboard bench for code_fetch_unit: stimulus pushes expected fetch
// results with their due cycle; a negedge monitor pops and compares.
module tb_code_fetch_unit;

  localparam int AW = 10;
  localparam int IW = 64;
  localparam logic [63:0] REJ_WORD = 64'h0000_0006_0000_0000;
  localparam logic [1:0] S_P1 = 2'd0, S_JT = 2'd1, S_JF = 2'd2, S_IMM = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] code_tdata = '0;
  logic          code_tvalid = 1'b0, code_tlast = 1'b0, code_tready;
  logic          start = 1'b0, inst_rd_en = 1'b0, PC_en = 1'b0;
  logic [1:0]    PC_sel = 2'd0;
  logic [7:0]    jt = 8'd0, jf = 8'd0;
  logic [31:0]   imm = 32'd0;
  logic [AW-1:0] jmp_correction = '0;
  logic          acc = 1'b0, rej = 1'b0;
  logic [IW-1:0] instr_out;
  logic          instr_vld, running, load_ovf, oob_err;
  logic [AW:0]   prog_len;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  code_fetch_unit #(.CODE_ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .code_tdata(code_tdata), .code_tvalid(code_tvalid), .code_tlast(code_tlast),
    .code_tready(code_tready), .start(start), .inst_rd_en(inst_rd_en),
    .PC_en(PC_en), .PC_sel(PC_sel), .jt(jt), .jf(jf), .imm(imm),
    .jmp_correction(jmp_correction), .acc(acc), .rej(rej),
    .instr_out(instr_out), .instr_vld(instr_vld), .running(running),
    .prog_len(prog_len), .load_ovf(load_ovf), .oob_err(oob_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every instr_vld must match the head of the scoreboard on time
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (instr_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vld actual=%h required=no_fetch", instr_out);
        end else begin
          e = exp_q.pop_front();
          if (instr_out !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL fetch_data actual=%h@%0d required=%h@%0d", instr_out, cyc, e.data, e.due);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missing_vld actual=none required=%h@%0d", e.data, e.due);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] base, input int n, input logic with_last);
    for (int i = 0; i < n; i++) begin
      code_tvalid = 1'b1;
      code_tdata  = base + 64'(i);
      code_tlast  = with_last && (i == n - 1);
      tick();
    end
    code_tvalid = 1'b0;
    code_tlast  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run(input logic is_acc);
    acc = is_acc;
    rej = ~is_acc;
    tick();
    acc = 1'b0;
    rej = 1'b0;
  endtask

  task automatic step(input logic rd, input logic en, input logic [1:0] sel,
                      input logic [7:0] t, input logic [7:0] f, input logic [31:0] im,
                      input logic [AW-1:0] corr, input logic [63:0] exp_d);
    inst_rd_en = rd; PC_en = en; PC_sel = sel;
    jt = t; jf = f; imm = im; jmp_correction = corr;
    if (rd) exp_q.push_back('{exp_d, cyc + 1});
    tick();
    inst_rd_en = 1'b0; PC_en = 1'b0; PC_sel = 2'd0;
    jt = 8'd0; jf = 8'd0; imm = 32'd0; jmp_correction = '0;
  endtask

  initial begin
    logic [63:0] oob_exp_data;
    logic        oob_exp_flag;
`ifdef FETCH_OOB_CHECK_EN
    oob_exp_data = REJ_WORD;
    oob_exp_flag = 1'b1;
`else
    oob_exp_data = 64'h1002;
    oob_exp_flag = 1'b0;
`endif
    #2;
    chk("rst_tready", 64'(code_tready), 64'd1);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_vld", 64'(instr_vld), 64'd0);
    chk("rst_prog_len", 64'(prog_len), 64'd0);
    chk("rst_load_ovf", 64'(load_ovf), 64'd0);
    chk("rst_oob_err", 64'(oob_err), 64'd0);
    chk("rst_instr_out", instr_out, 64'd0);
    #10 rst = 1'b1;
    tick();

    // basic load and sequential fetch
    load(64'hA0, 4, 1'b1);
    chk("t1_prog_len", 64'(prog_len), 64'd4);
    chk("t1_load_ovf", 64'(load_ovf), 64'd0);
    chk("t1_not_running", 64'(running), 64'd0);
    do_start();
    chk("t1_running", 64'(running), 64'd1);
    chk("t1_tready_low", 64'(code_tready), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, S_P1, 8'd0, 8'd0, 32'd0, '0, 64'hA0 + 64'(i));
    chk("t1_oob_err", 64'(oob_err), 64'd0);
    finish_run(1'b1);
    chk("t1_done", 64'(running), 64'd0);

    // start with a LOADED beat (load wins) and start during LOADING (ignored)
    for (int i = 0; i < 16; i++) begin
      code_tvalid = 1'b1;
      code_tdata  = 64'h100 + 64'(i);
      code_tlast  = (i == 15);
      start       = (i == 0) || (i == 2);
      tick();
      start = 1'b0;
      if (i == 2) chk("t2_start_in_loading", 64'(running), 64'd0);
    end
    code_tvalid = 1'b0;
    code_tlast  = 1'b0;
    chk("t2_prog_len", 64'(prog_len), 64'd16);
    chk("t2_not_running", 64'(running), 64'd0);
    do_start();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, S_P1, 8'd0, 8'd0, 32'd0, '0, 64'd0);
    step(1'b0, 1'b1, S_JT, 8'd3, 8'd0, 32'd0, 10'd2, 64'd0);   // 5-2+3+1 = 7
    step(1'b1, 1'b1, S_P1, 8'd0, 8'd0, 32'd0, '0, 64'h107);    // reads old PC 7
    step(1'b1, 1'b0, S_P1, 8'd0, 8'd0, 32'd0, '0, 64'h108);
    // done in same cycle as fetch and PC update: no instr_vld, PC back to 0
    acc = 1'b1; inst_rd_en = 1'b1; PC_en = 1'b1;
    tick();
    acc = 1'b0; inst_rd_en = 1'b0; PC_en = 1'b0;
    chk("t2_done_running", 64'(running), 64'd0);
    chk("t2_done_tready", 64'(code_tready), 64'd1);
    do_start();
    step(1'b1, 1'b0, S_P1, 8'd0, 8'd0, 32'd0, '0, 64'h100);
    finish_run(1'b0);

    // overflow load without tlast, then wrap-around jumps
    load(64'h1000, 1024, 1'b0);
    chk("t3_prog_len", 64'(prog_len), 64'd1024);
    chk("t3_load_ovf", 64'(load_ovf), 64'd1);
    chk("t3_tready", 64'(code_tready), 64'd1);
    chk("t3_not_running", 64'(running), 64'd0);
    do_start();
    step(1'b0, 1'b1, S_IMM, 8'd0, 8'd0, 32'd1019, '0, 64'd0);      // -> 1020
    step(1'b1, 1'b1, S_IMM, 8'd0, 8'd0, 32'd10, '0, 64'h13FC);     // -> 7 (wrap)
    step(1'b1, 1'b1, S_JF, 8'd0, 8'd4, 32'd0, 10'd3, 64'h1007);    // -> 9
    step(1'b1, 1'b1, S_IMM, 8'd0, 8'd0, 32'd1013, '0, 64'h1009);   // -> 1023
    step(1'b1, 1'b1, S_P1, 8'd0, 8'd0, 32'd0, '0, 64'h13FF);       // -> 0
    step(1'b1, 1'b0, S_P1, 8'd0, 8'd0, 32'd0, '0, 64'h1000);
    finish_run(1'b0);

    // start together with a new single-beat program: load wins, ovf clears
    code_tvalid = 1'b1; code_tlast = 1'b1; code_tdata = 64'hC0; start = 1'b1;
    tick();
    code_tvalid = 1'b0; code_tlast = 1'b0; start = 1'b0;
    chk("t4_running", 64'(running), 64'd0);
    chk("t4_prog_len", 64'(prog_len), 64'd1);
    chk("t4_load_ovf_clr", 64'(load_ovf), 64'd0);

    // fetch past the end of a 2-word program
    load(64'hB0, 2, 1'b1);
    chk("t5_prog_len", 64'(prog_len), 64'd2);
    do_start();
    step(1'b1, 1'b1, S_P1, 8'd0, 8'd0, 32'd0, '0, 64'hB0);
    step(1'b0, 1'b1, S_P1, 8'd0, 8'd0, 32'd0, '0, 64'd0);
    step(1'b1, 1'b0, S_P1, 8'd0, 8'd0, 32'd0, '0, oob_exp_data);
    chk("t5_oob_err", 64'(oob_err), 64'(oob_exp_flag));
    finish_run(1'b1);
    do_start();
    chk("t5_oob_err_clr", 64'(oob_err), 64'd0);
    finish_run(1'b0);

    // reset during a load discards the partial program
    load(64'hD0, 3, 1'b0);
    rst = 1'b0;
    #2;
    chk("t6_prog_len", 64'(prog_len), 64'd0);
    chk("t6_tready", 64'(code_tready), 64'd1);
    chk("t6_running", 64'(running), 64'd0);
    #10 rst = 1'b1;
    tick();
    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
